// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, zero padding to MIN_FRAME and IFG enforcement.
// Build option TSMAC_TX_FCS_EN appends the CRC-32 FCS after the payload/padding.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    input  logic       s_err,
    output logic       s_ready,
    output logic       tx_en_gm,
    output logic       tx_er_gm,
    output logic [7:0] txd_gm,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // s_valid/s_ready: a byte transfers at every rising edge where both are 1. Once s_ready
    // rises in SFD the source must hold s_valid high up to s_last; a low s_valid is an underrun.

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP} state_t;

`ifdef TSMAC_TX_FCS_EN
    localparam state_t TAIL = FCS;
`else
    localparam state_t TAIL = IFG;
`endif

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);

    state_t      state;
    logic [7:0]  pre_cnt;
    logic [7:0]  ifg_cnt;
    logic [10:0] byte_cnt;
    logic [10:0] byte_inc;

    assign byte_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign state_dbg = state;

`ifdef TSMAC_TX_FCS_EN
    logic [31:0] crc;
    logic [1:0]  fcs_cnt;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Tracks exactly the bytes the FSM emits after the SFD; an underrun byte counts as 0x00.
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (state == PRE && pre_cnt == PRE_LAST) begin
            crc <= '1;
        end else if (state == SFD || state == DATA) begin
            crc <= crc_next(crc, s_valid ? s_data : 8'h00);
        end else if (state == PAD) begin
            crc <= crc_next(crc, 8'h00);
        end
    end
`endif

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            tx_en_gm <= 1'b0;
            tx_er_gm <= 1'b0;
            txd_gm   <= 8'h00;
            busy     <= 1'b0;
            pre_cnt  <= 8'd0;
            ifg_cnt  <= 8'd0;
            byte_cnt <= 11'd0;
`ifdef TSMAC_TX_FCS_EN
            fcs_cnt  <= 2'd0;
`endif
        end else begin
            // Outputs are rebuilt every cycle; each state sets only what it drives.
            tx_en_gm <= 1'b0;
            tx_er_gm <= 1'b0;
            txd_gm   <= 8'h00;
            ifg_cnt  <= 8'd0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        state    <= PRE;
                        busy     <= 1'b1;
                        tx_en_gm <= 1'b1;
                        txd_gm   <= 8'h55;
                        pre_cnt  <= 8'd1;
                    end
                end
                PRE: begin
                    tx_en_gm <= 1'b1;
                    if (pre_cnt == PRE_LAST) begin
                        state    <= SFD;
                        txd_gm   <= 8'hD5;
                        s_ready  <= 1'b1;
                        byte_cnt <= 11'd0;
                    end else begin
                        pre_cnt <= pre_cnt + 8'd1;
                        txd_gm  <= 8'h55;
                    end
                end
                SFD, DATA: begin
                    tx_en_gm <= 1'b1;
                    byte_cnt <= byte_inc;
                    if (s_valid) begin
                        txd_gm   <= s_data;
                        tx_er_gm <= s_err;
                        if (s_last) begin
                            s_ready <= 1'b0;
                            state   <= (byte_inc < MIN_CNT) ? PAD : TAIL;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        tx_er_gm <= 1'b1;
                        if (s_last) begin
                            s_ready <= 1'b0;
                            state   <= IFG;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PAD: begin
                    tx_en_gm <= 1'b1;
                    byte_cnt <= byte_inc;
                    if (byte_inc >= MIN_CNT) begin
                        state <= TAIL;
                    end
                end
`ifdef TSMAC_TX_FCS_EN
                FCS: begin
                    tx_en_gm <= 1'b1;
                    fcs_cnt  <= fcs_cnt + 2'd1;
                    case (fcs_cnt)
                        2'd0:    txd_gm <= ~crc[7:0];
                        2'd1:    txd_gm <= ~crc[15:8];
                        2'd2:    txd_gm <= ~crc[23:16];
                        default: txd_gm <= ~crc[31:24];
                    endcase
                    if (fcs_cnt == 2'd3) begin
                        state <= IFG;
                    end
                end
`endif
                IFG: begin
                    if (ifg_cnt == IFG_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ifg_cnt <= ifg_cnt + 8'd1;
                    end
                end
                DROP: begin
                    if (s_valid && s_last) begin
                        s_ready <= 1'b0;
                        state   <= IFG;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
GMII transmit framer that sits directly upstream of the GMII-to-RGMII output converter in the TSMAC PHY path. It accepts a payload byte stream over a valid/ready/last handshake and produces tx_en_gm / tx_er_gm / txd_gm for the converter. For each frame it inserts preamble and SFD, zero-pads short frames to the minimum size, optionally appends the CRC-32 FCS, and enforces the inter-frame gap.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD (0xD5).
MIN_FRAME, 60, minimum bytes sent after the SFD, excluding FCS; short payloads are zero-padded up to this count.
IFG_BYTES, 12, idle cycles forced between the last tx_en_gm=1 cycle of a frame and the next frame start.

Ports:
tx_clk  in  1  GMII transmit clock (125 MHz); all logic is on its rising edge.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  payload byte valid.
s_data  in  8  payload byte.
s_last  in  1  marks the last payload byte of the frame.
s_err  in  1  the accompanying byte is transmitted with tx_er_gm=1.
s_ready  out  1  framer accepts a byte this cycle.
tx_en_gm  out  1  GMII TX_EN.
tx_er_gm  out  1  GMII TX_ER.
txd_gm  out  8  GMII TXD.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all outputs are 0, the state is IDLE and all counters are 0. Asserting rst mid-frame truncates the frame immediately. The first frame after reset release needs no IFG.
- tx_en_gm, tx_er_gm, txd_gm and s_ready are registered. A transfer occurs when s_valid and s_ready are both 1 at an edge.
- The FSM has seven states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, plus DROP.
- IDLE: outputs are 0. If s_valid is sampled 1, go to PRE; the first 0x55 appears on txd_gm in the next cycle with tx_en_gm=1. No byte is consumed in IDLE.
- PRE: send PREAMBLE_LEN cycles of 0x55, then go to SFD.
- SFD: send one cycle of 0xD5, then go to DATA. s_ready is registered high so that the first payload byte transfers on the SFD-to-DATA boundary.
- DATA: each transferred byte is driven on txd_gm one cycle later with tx_en_gm=1 and tx_er_gm=s_err. An 11-bit byte counter increments per byte sent after the SFD and saturates at 2047.
  - On transfer with s_last=1: go to PAD if count < MIN_FRAME, otherwise go to FCS (or IFG when the FCS feature is out).
- Underrun: s_valid=0 while in DATA is an underrun.
  - Send one cycle with tx_en_gm=1, tx_er_gm=1, txd_gm=0x00, then go to DROP.
  - DROP: tx_en_gm=0 and s_ready=1; discard bytes until s_last is transferred, then go to IFG.
  - If s_last coincides with the underrun cycle, go straight to IFG.
- PAD: send 0x00 until count reaches MIN_FRAME, then go to FCS or IFG.
- FCS: send 4 bytes, then go to IFG.
- IFG: outputs are 0 for IFG_BYTES cycles, then go to IDLE. A frame pending on s_valid starts on the following cycle, so the tx_en_gm low gap is exactly IFG_BYTES cycles.
- s_ready is 0 in IDLE, PRE, PAD, FCS and IFG. It is never asserted while the output is stalled, and the framer never stalls the output mid-frame.
- busy is registered and is 1 in every state except IDLE.

Optional Feature:
Macro: TSMAC_TX_FCS_EN.
- Defined:
  - The CRC-32 is reflected, polynomial 0xEDB88320, initialised to 0xFFFFFFFF on SFD.
  - It is updated over every byte sent in DATA and PAD, including the zero byte of an underrun cycle.
  - In FCS, the complemented CRC is sent LSB-byte first: bits [7:0] first, [31:24] last.
  - Frames that end via DROP get no FCS.
- Undefined: the FCS state and CRC logic are absent. PAD or DATA(s_last) goes directly to IFG, and the frame is 4 cycles shorter.

Test Plan:
1. FCS on, 60-byte payload 0x00..0x3B -> tx_en_gm high for 72 cycles (7x 0x55, 0xD5, the 60 payload bytes, 4 FCS bytes); FCS equals the bench CRC-32 model; tx_er_gm stays 0 throughout.
2. FCS on, 10-byte payload -> 10 payload bytes followed by 50 bytes of 0x00; tx_en_gm high for 72 cycles; FCS is computed over all 60 bytes; s_ready is high for exactly 10 transfers.
3. Back-to-back frames with s_valid held high -> exactly 12 cycles of tx_en_gm=0 between frames; the second preamble starts on cycle 13 after the first frame ends.
4. s_valid dropped at payload byte 20 -> one cycle of tx_en_gm=1, tx_er_gm=1, txd_gm=0x00, then tx_en_gm=0 with no FCS; the remaining bytes up to s_last are consumed; the next frame starts after the 12-cycle IFG.
5. s_err=1 on payload byte 5 -> that byte appears on txd_gm with tx_er_gm=1; the frame otherwise completes normally, including FCS.
6. rst pulsed during byte 30 -> tx_en_gm, tx_er_gm, txd_gm, s_ready and busy go to 0 without waiting for a clock edge; after release, a new 60-byte frame is transmitted correctly with no leading IFG. With the FCS macro undefined, repeating scenario 1 gives 68 tx_en_gm cycles.
